// File: rtl/gelu_pkg.sv
`default_nettype none
//============================================================================
// Module      : gelu_pkg
// Description : Shared Q6.10 constants, table geometry and FSM encodings
//               for the GELU lookup-table loader.
// Revision    : 1.0
//============================================================================
package gelu_pkg;

    localparam int FRAC_BITS  = 10;
    localparam int DEPTH      = 64;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int LUT_MIN    = -4096;
    localparam int LUT_MAX    = 3968;
    localparam int STEP_SHIFT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Source selection for a registered lookup result
    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_MEM  = 2'd1,
        RD_PASS = 2'd2
    } rd_sel_t;

endpackage
`default_nettype wire

// File: rtl/gelu_lut_mem.sv
`default_nettype none
//============================================================================
// Module      : gelu_lut_mem
// Description : Table storage with synchronous write and a registered,
//               read-enabled output that holds between reads.
// Revision    : 1.0
//============================================================================
module gelu_lut_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array is left unreset so it maps onto RAM macros
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/gelu_lut_loader.sv
`default_nettype none
//============================================================================
// Module      : gelu_lut_loader
// Description : Loads a GELU lookup table word by word and serves
//               single-cycle pipelined Q6.10 lookups from it.
//               Optional macro GELU_LUT_CHECKSUM_EN adds load checksum.
// Revision    : 1.0
//============================================================================
module gelu_lut_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = gelu_pkg::FRAC_BITS,
    parameter int DEPTH      = gelu_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] rd_x,
    input  logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid_out,
    output logic                  rd_out_of_range,
    output logic                  rd_err,
`ifdef GELU_LUT_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] exp_sum,
    output logic                  sum_err,
`endif
    output logic                  table_ready,
    output logic                  load_done
);

    import gelu_pkg::*;

    // Table spans DEPTH steps of 1/8 starting at -4.0
    localparam int c_addr_w     = $clog2(DEPTH);
    localparam int c_step_shift = FRAC_BITS - 3;
    localparam int c_lut_min    = -(DEPTH << (c_step_shift - 1));
    localparam int c_lut_max    = -c_lut_min - (1 << c_step_shift);

    localparam logic signed [DATA_WIDTH-1:0] c_min_w  = DATA_WIDTH'(c_lut_min);
    localparam logic signed [DATA_WIDTH-1:0] c_max_w  = DATA_WIDTH'(c_lut_max);
    localparam logic        [c_addr_w-1:0]   c_last_a = c_addr_w'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_wr_ready;
    logic [c_addr_w-1:0]   r_wptr;
    logic                  r_table_ready;
    logic                  r_load_done;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_sum_ok;

    logic                  w_below;
    logic                  w_above;
    logic [DATA_WIDTH-1:0] w_biased;
    logic [c_addr_w-1:0]   w_raddr;
    rd_sel_t               w_sel;
    rd_sel_t               r_sel;
    logic [DATA_WIDTH-1:0] r_x;
    logic                  r_valid_out;
    logic                  r_err;
    logic                  r_oor;
    logic [DATA_WIDTH-1:0] w_mem_q;

    assign w_accept = (r_state == ST_LOAD) && wr_valid && !load_start;
    assign w_last   = w_accept && (r_wptr == c_last_a);

    //------------------------------------------------------------------------
    // Load FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_wr_ready = 1'b1;
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_last) begin
                    w_state_nxt = w_sum_ok ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wr_ready = w_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_table_ready <= 1'b0;
            r_load_done   <= 1'b0;
        end else begin
            r_load_done <= w_last;
            if (load_start) begin
                r_wptr        <= '0;
                r_table_ready <= 1'b0;
            end else if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
                if (w_last && w_sum_ok) begin
                    r_table_ready <= 1'b1;
                end
            end
        end
    end

    assign table_ready = r_table_ready;
    assign load_done   = r_load_done;

`ifdef GELU_LUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_exp_sum;
    logic [DATA_WIDTH-1:0] w_sum_nxt;
    logic                  r_sum_err;

    assign w_sum_nxt = r_sum + wr_data;
    assign w_sum_ok  = (w_sum_nxt == r_exp_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_exp_sum <= '0;
            r_sum_err <= 1'b0;
        end else if (load_start) begin
            r_sum     <= '0;
            r_exp_sum <= exp_sum;
            r_sum_err <= 1'b0;
        end else if (w_accept) begin
            r_sum <= w_sum_nxt;
            if (w_last && !w_sum_ok) begin
                r_sum_err <= 1'b1;
            end
        end
    end

    assign sum_err = r_sum_err;
`else
    assign w_sum_ok = 1'b1;
`endif

    //------------------------------------------------------------------------
    // Lookup path: classify now, read memory and register the selection
    //------------------------------------------------------------------------
    assign w_below  = $signed(rd_x) <  c_min_w;
    assign w_above  = $signed(rd_x) >= c_max_w;
    assign w_biased = rd_x - c_min_w;
    assign w_raddr  = c_addr_w'(w_biased >> c_step_shift);

    always_comb begin
        w_sel = RD_ZERO;
        if (r_table_ready) begin
            if (w_below) begin
                w_sel = RD_ZERO;
            end else if (w_above) begin
                w_sel = RD_PASS;
            end else begin
                w_sel = RD_MEM;
            end
        end
    end

    gelu_lut_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (c_addr_w)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_accept),
        .i_waddr (r_wptr),
        .i_wdata (wr_data),
        .i_re    (rd_valid && (w_sel == RD_MEM)),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_q)
    );

    // Result registers only move on a lookup so outputs hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out <= 1'b0;
            r_sel       <= RD_ZERO;
            r_x         <= '0;
            r_err       <= 1'b0;
            r_oor       <= 1'b0;
        end else begin
            r_valid_out <= rd_valid;
            if (rd_valid) begin
                r_sel <= w_sel;
                r_x   <= rd_x;
                r_err <= !r_table_ready;
                r_oor <= r_table_ready && (w_below || w_above);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (r_sel)
            RD_MEM:  rd_data = w_mem_q;
            RD_PASS: rd_data = r_x;
            default: rd_data = '0;
        endcase
    end

    assign rd_valid_out    = r_valid_out;
    assign rd_err          = r_err;
    assign rd_out_of_range = r_oor;

endmodule
`default_nettype wire

// File: tb/tb_gelu_lut_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_gelu_lut_loader
// Description : Self-checking bench for gelu_lut_loader (optionally with
//               GELU_LUT_CHECKSUM_EN).
// Revision    : 1.0
//============================================================================
module tb_gelu_lut_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_x = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid_out;
    logic        rd_out_of_range;
    logic        rd_err;
    logic        table_ready;
    logic        load_done;
`ifdef GELU_LUT_CHECKSUM_EN
    logic [15:0] exp_sum = '0;
    logic        sum_err;
`endif

    always #5 clk = ~clk;

    gelu_lut_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start      (load_start),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_x            (rd_x),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_valid_out    (rd_valid_out),
        .rd_out_of_range (rd_out_of_range),
        .rd_err          (rd_err),
`ifdef GELU_LUT_CHECKSUM_EN
        .exp_sum         (exp_sum),
        .sum_err         (sum_err),
`endif
        .table_ready     (table_ready),
        .load_done       (load_done)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        err;
        logic        oor;
    } rd_exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] d;
        logic        oor;
    } vec_t;

    rd_exp_t     sb_q[$];
    rd_exp_t     last_exp = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] ref_mem [64];
    int          m_st = 0;
    int          m_wptr = 0;
    bit          m_ready = 0;
    bit          m_ld = 0;
    bit          m_sumerr = 0;
    logic [15:0] m_sum = '0;
    logic [15:0] m_exp = '0;
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rd_exp_t model_lookup(input logic [15:0] x);
        rd_exp_t e;
        int      sx;
        e  = '0;
        sx = int'($signed(x));
        if (!m_ready) begin
            e.err = 1'b1;
        end else if (sx < -4096) begin
            e.oor = 1'b1;
        end else if (sx >= 3968) begin
            e.d   = x;
            e.oor = 1'b1;
        end else begin
            e.d = ref_mem[(sx + 4096) / 128];
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_x();
        int v;
        if ($urandom_range(0, 3) == 0) begin
            return 16'($urandom);
        end
        v = int'($urandom_range(0, 8063)) - 4096;
        return 16'(v);
    endfunction

    // One clock of stimulus: drive at negedge, check level outputs, then
    // advance the reference model by the coming rising edge.
    task automatic apply(input bit ls, input bit wv, input logic [15:0] wd,
                         input bit rv, input logic [15:0] rx,
                         input bit use_e, input rd_exp_t e_in);
        rd_exp_t e;
        @(negedge clk);
        load_start = ls;
        wr_valid   = wv;
        wr_data    = wd;
        rd_valid   = rv;
        rd_x       = rx;
        #1;
        chk("wr_ready", wr_ready, (m_st == 1));
        chk("table_ready", table_ready, m_ready);
        chk("load_done", load_done, m_ld);
`ifdef GELU_LUT_CHECKSUM_EN
        chk("sum_err", sum_err, m_sumerr);
`endif
        if (rv) begin
            e = use_e ? e_in : model_lookup(rx);
            sb_q.push_back(e);
        end
        m_ld = 1'b0;
        if (ls) begin
            m_st     = 1;
            m_wptr   = 0;
            m_ready  = 1'b0;
            m_sum    = '0;
            m_sumerr = 1'b0;
`ifdef GELU_LUT_CHECKSUM_EN
            m_exp    = exp_sum;
`endif
        end else if (m_st == 1 && wv) begin
            ref_mem[m_wptr] = wd;
            m_sum = m_sum + wd;
            if (m_wptr == 63) begin
                m_ld   = 1'b1;
                m_wptr = 0;
`ifdef GELU_LUT_CHECKSUM_EN
                if (m_sum == m_exp) begin
                    m_st = 2; m_ready = 1'b1;
                end else begin
                    m_st = 0; m_sumerr = 1'b1;
                end
`else
                m_st = 2; m_ready = 1'b1;
`endif
            end else begin
                m_wptr++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic load_table(input logic [15:0] base, input logic [15:0] stride);
        apply(1, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 64; i++) apply(0, 1, 16'(base + stride * 16'(i)), 0, '0, 0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " wr_ready"}, wr_ready, 0);
        chk({tag, " rd_data"}, rd_data, 0);
        chk({tag, " rd_valid_out"}, rd_valid_out, 0);
        chk({tag, " rd_out_of_range"}, rd_out_of_range, 0);
        chk({tag, " rd_err"}, rd_err, 0);
        chk({tag, " table_ready"}, table_ready, 0);
        chk({tag, " load_done"}, load_done, 0);
    endtask

    // Output monitor: latency, scoreboard pop, and hold when idle
    always @(posedge clk) begin
        logic    v;
        rd_exp_t e;
        v = rd_valid;
        #1;
        if (rst_n) begin
            chk("rd_valid_out latency", rd_valid_out, v);
            if (rd_valid_out) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected rd_valid_out", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_err", rd_err, e.err);
                    chk("rd_out_of_range", rd_out_of_range, e.oor);
                    last_exp = e;
                end
            end else begin
                chk("rd_data hold", rd_data, last_exp.d);
                chk("rd_err hold", rd_err, last_exp.err);
                chk("rd_out_of_range hold", rd_out_of_range, last_exp.oor);
            end
        end
    end

    initial begin
        int guard;

        vecs[0]  = '{16'h0000, 16'd32,   1'b0};
        vecs[1]  = '{16'hF000, 16'd0,    1'b0};
        vecs[2]  = '{16'hF080, 16'd1,    1'b0};
        vecs[3]  = '{16'h0F7F, 16'd62,   1'b0};
        vecs[4]  = '{16'h0F80, 16'h0F80, 1'b1};
        vecs[5]  = '{16'hE000, 16'd0,    1'b1};
        vecs[6]  = '{16'hEFFF, 16'd0,    1'b1};
        vecs[7]  = '{16'h7FFF, 16'h7FFF, 1'b1};
        vecs[8]  = '{16'h8000, 16'd0,    1'b1};
        vecs[9]  = '{16'h0400, 16'd40,   1'b0};
        vecs[10] = '{16'hFC00, 16'd24,   1'b0};
        vecs[11] = '{16'h0081, 16'd33,   1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Writes and lookups in IDLE
        for (int i = 0; i < 3; i++) apply(0, 1, 16'h1234, 0, '0, 0, '0);
        apply(0, 0, '0, 1, 16'h0000, 0, '0);

        // Index table; lookup on the final write cycle must report rd_err
        apply(1, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 63; i++) apply(0, 1, 16'(i), 0, '0, 0, '0);
        apply(0, 1, 16'd63, 1, 16'h0000, 0, '0);
        apply(0, 0, '0, 1, 16'h0000, 0, '0);

        foreach (vecs[i]) apply(0, 0, '0, 1, vecs[i].x, 1, '{vecs[i].d, 1'b0, vecs[i].oor});
        idle(2);

        // Restart mid-load; the word presented with load_start is dropped
        apply(1, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 20; i++) apply(0, 1, 16'(16'h0100 + i), (i == 10), 16'h0000, 0, '0);
        apply(1, 1, 16'hDEAD, 0, '0, 0, '0);
        for (int i = 0; i < 64; i++) apply(0, 1, 16'(16'h0200 + 5 * i), 0, '0, 0, '0);
        for (int a = 0; a < 64; a++) apply(0, 0, '0, 1, 16'(a * 128 - 4096 + int'($urandom_range(0, 127))), 0, '0);

        // Random wr_valid with back-to-back lookups
        apply(1, 0, '0, 1, rand_x(), 0, '0);
        guard = 0;
        while (m_st == 1 && guard < 2000) begin
            apply(0, 1'($urandom_range(0, 1)), 16'($urandom), 1, rand_x(), 0, '0);
            guard++;
        end
        if (guard >= 2000) chk("random load bound", 0, 1);
        for (int i = 0; i < 24; i++) apply(0, 0, '0, 1, rand_x(), 0, '0);
        idle(2);

        // Asynchronous reset in the middle of a load
        apply(1, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 30; i++) apply(0, 1, 16'(16'h5500 + i), 0, '0, 0, '0);
        @(negedge clk);
        wr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-load reset");
        m_st = 0; m_wptr = 0; m_ready = 1'b0; m_ld = 1'b0; m_sumerr = 1'b0;
        sb_q.delete();
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        apply(0, 0, '0, 1, 16'h0000, 0, '0);
        load_table(16'hA000, 16'd3);
        for (int i = 0; i < 8; i++) apply(0, 0, '0, 1, rand_x(), 0, '0);
        idle(2);

`ifdef GELU_LUT_CHECKSUM_EN
        exp_sum = 16'h07E0;
        load_table(16'd0, 16'd1);
        apply(0, 0, '0, 1, 16'h0000, 0, '0);
        chk("checksum match table_ready", table_ready, 1);
        exp_sum = 16'h07E1;
        load_table(16'd0, 16'd1);
        apply(0, 0, '0, 1, 16'h0000, 0, '0);
        chk("checksum mismatch sum_err", sum_err, 1);
        chk("checksum mismatch table_ready", table_ready, 0);
        idle(2);
`endif

        idle(2);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
